// File: rtl/bp_zynq_cfg_sequencer.sv
// Runtime cfg-bus sequencer: configures every enabled core while frozen,
// then unfreezes them all, over a one-outstanding write req/resp channel.
module bp_zynq_cfg_sequencer #(
    parameter int                       num_core_p       = 2,
    parameter int                       paddr_width_p    = 34,
    parameter int                       data_width_p     = 64,
    parameter logic [paddr_width_p-1:0] cfg_base_p       = 34'h0020_0000,
    parameter int                       core_stride_lg_p = 24,
    parameter int                       timeout_p        = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [num_core_p-1:0]    core_mask_i,
    input  logic [paddr_width_p-1:0] npc_i,
    input  logic [1:0]               icache_mode_i,
    input  logic [1:0]               dcache_mode_i,
    output logic                     req_v_o,
    input  logic                     req_ready_and_i,
    output logic [paddr_width_p-1:0] req_addr_o,
    output logic [data_width_p-1:0]  req_data_o,
    input  logic                     resp_v_i,
    output logic                     resp_yumi_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);

    localparam int CW = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int TW = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_e;

    // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
    function automatic logic [CW:0] f_find(
        input logic [num_core_p-1:0] mask,
        input int                    from
    );
        logic [CW:0] res;
        res = '0;
        for (int i = num_core_p - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) res = {1'b1, CW'(i)};
        end
        return res;
    endfunction

    state_e                   r_state;
    logic [num_core_p-1:0]    r_mask;
    logic [paddr_width_p-1:0] r_npc;
    logic [1:0]               r_imode;
    logic [1:0]               r_dmode;
    logic [CW-1:0]            r_core;
    logic                     r_phase;
    logic [1:0]               r_step;
    logic [TW-1:0]            r_tmo;
    logic                     r_err;

    state_e                   w_state_nxt;
    logic [CW-1:0]            w_core_nxt;
    logic                     w_phase_nxt;
    logic [1:0]               w_step_nxt;
    logic [TW-1:0]            w_tmo_nxt;
    logic                     w_err_nxt;
    logic                     w_latch;
    logic [CW:0]              w_first;
    logic [CW:0]              w_next;
    logic [CW:0]              w_bfirst;
    logic [TW-1:0]            w_tmo_inc;
    logic                     w_send;
    logic [paddr_width_p-1:0] w_off;
    logic [paddr_width_p-1:0] w_core_base;
    logic [data_width_p-1:0]  w_data;

    assign w_first   = f_find(core_mask_i, 0);
    assign w_next    = f_find(r_mask, int'(r_core) + 1);
    assign w_bfirst  = f_find(r_mask, 0);
    assign w_tmo_inc = r_tmo + TW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_core_nxt  = r_core;
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_latch     = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_core_nxt  = w_first[CW-1:0];
                    w_phase_nxt = 1'b0;
                    w_step_nxt  = 2'd0;
                    w_state_nxt = w_first[CW] ? S_SEND : S_DONE;
                end
            end
            S_SEND: begin
                if (req_ready_and_i) begin
                    w_state_nxt = S_WAIT;
                    w_tmo_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (resp_v_i) begin
                    w_state_nxt = S_SEND;
                    if (!r_phase) begin
                        if (r_step != 2'd3) begin
                            w_step_nxt = r_step + 2'd1;
                        end else if (w_next[CW]) begin
                            w_core_nxt = w_next[CW-1:0];
                            w_step_nxt = 2'd0;
                        end else begin
                            w_phase_nxt = 1'b1;
                            w_core_nxt  = w_bfirst[CW-1:0];
                        end
                    end else if (w_next[CW]) begin
                        w_core_nxt = w_next[CW-1:0];
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (w_tmo_inc == TW'(timeout_p)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            default: ;
        endcase
        // A stray response is always flagged, even over a restart's clear.
        if (resp_v_i && (r_state != S_WAIT)) w_err_nxt = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_npc   <= '0;
            r_imode <= '0;
            r_dmode <= '0;
            r_core  <= '0;
            r_phase <= 1'b0;
            r_step  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_core  <= w_core_nxt;
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
            if (w_latch) begin
                r_mask  <= core_mask_i;
                r_npc   <= npc_i;
                r_imode <= icache_mode_i;
                r_dmode <= dcache_mode_i;
            end
        end
    end

    always_comb begin
        w_off  = '0;
        w_data = '0;
        if (!r_phase) begin
            unique case (r_step)
                2'd0: begin
                    w_off  = paddr_width_p'(12'h000);
                    w_data = data_width_p'(1);
                end
                2'd1: begin
                    w_off  = paddr_width_p'(12'h010);
                    w_data = data_width_p'(r_imode);
                end
                2'd2: begin
                    w_off  = paddr_width_p'(12'h018);
                    w_data = data_width_p'(r_dmode);
                end
                2'd3: begin
                    w_off  = paddr_width_p'(12'h020);
                    w_data = data_width_p'(r_npc);
                end
                default: ;
            endcase
        end
    end

    assign w_send      = (r_state == S_SEND);
    assign w_core_base = paddr_width_p'(r_core) << core_stride_lg_p;

    assign req_v_o     = w_send;
    assign req_addr_o  = w_send ? (cfg_base_p + w_core_base + w_off) : '0;
    assign req_data_o  = w_send ? w_data : '0;
    assign resp_yumi_o = resp_v_i & ~reset_i;
    assign busy_o      = w_send | (r_state == S_WAIT);
    assign done_o      = (r_state == S_DONE);
    assign error_o     = r_err;

endmodule

// File: tb/tb_bp_zynq_cfg_sequencer.sv
// Scoreboard bench: the expected write list is built from the mask,
// a monitor pops it on every accepted request.
module tb_bp_zynq_cfg_sequencer;

    localparam int NC  = 4;
    localparam int TMO = 16;
    localparam logic [33:0] BASE = 34'h0020_0000;

    typedef struct {
        logic [33:0] a;
        logic [63:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [NC-1:0] core_mask_i = '0;
    logic [33:0]   npc_i = '0;
    logic [1:0]    icache_mode_i = '0;
    logic [1:0]    dcache_mode_i = '0;
    logic          req_v_o;
    logic          req_ready_and_i = 1'b0;
    logic [33:0]   req_addr_o;
    logic [63:0]   req_data_o;
    logic          resp_v_i = 1'b0;
    logic          resp_yumi_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    wr_t exp_q[$];

    int  acc_count = 0;
    int  acc_cyc = 0;
    int  stall_cnt = 0;
    int  drop_idx = -1;
    int  bp_hold = 0;
    int  lat_max = 3;
    bit  force_ready = 1'b0;
    bit  slave_en = 1'b1;
    bit  mon_accept = 1'b0;

    bp_zynq_cfg_sequencer #(
        .num_core_p      (NC),
        .paddr_width_p   (34),
        .data_width_p    (64),
        .cfg_base_p      (BASE),
        .core_stride_lg_p(24),
        .timeout_p       (TMO)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .core_mask_i    (core_mask_i),
        .npc_i          (npc_i),
        .icache_mode_i  (icache_mode_i),
        .dcache_mode_i  (dcache_mode_i),
        .req_v_o        (req_v_o),
        .req_ready_and_i(req_ready_and_i),
        .req_addr_o     (req_addr_o),
        .req_data_o     (req_data_o),
        .resp_v_i       (resp_v_i),
        .resp_yumi_o    (resp_yumi_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Memory-side responder: random ready, random response latency.
    initial begin
        int resp_cd;
        resp_cd = -1;
        forever begin
            @(posedge clk);
            #1;
            if (!slave_en) begin
                resp_cd    = -1;
                mon_accept = 1'b0;
            end else begin
                if (mon_accept) begin
                    mon_accept = 1'b0;
                    if (acc_count - 1 == drop_idx) resp_cd = -1;
                    else resp_cd = int'($urandom_range(0, lat_max));
                end
                if (resp_cd == 0) begin
                    resp_v_i = 1'b1;
                    resp_cd  = -1;
                end else begin
                    resp_v_i = 1'b0;
                    if (resp_cd > 0) resp_cd--;
                end
                if (bp_hold > 0) begin
                    req_ready_and_i = 1'b0;
                    bp_hold--;
                end else begin
                    req_ready_and_i = force_ready ? 1'b1
                                    : ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    // Monitor: scoreboard pops, handshake stability, response timing.
    initial begin
        bit          prev_v, prev_rdy, exp_req, exp_done;
        logic [33:0] prev_a;
        logic [63:0] prev_d;
        wr_t         e;
        prev_v = 0; prev_rdy = 0; exp_req = 0; exp_done = 0;
        prev_a = '0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_v = 0; exp_req = 0; exp_done = 0;
                continue;
            end
            if (exp_req) begin
                check("req_after_resp", req_v_o, 1);
                exp_req = 0;
            end
            if (exp_done) begin
                check("done_after_last", done_o, 1);
                exp_done = 0;
            end
            if (prev_v && !prev_rdy) begin
                check("hold_v", req_v_o, 1);
                check("hold_addr", req_addr_o, prev_a);
                check("hold_data", req_data_o, prev_d);
            end
            if (req_v_o && !req_ready_and_i) stall_cnt++;
            if (req_v_o && req_ready_and_i) begin
                if (exp_q.size() == 0) begin
                    check("unexp_req", req_v_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", req_addr_o, e.a);
                    check("wr_data", req_data_o, e.d);
                end
                acc_count++;
                acc_cyc    = cyc;
                mon_accept = 1'b1;
            end
            if (resp_v_i) begin
                check("yumi", resp_yumi_o, 1);
                if (busy_o && !req_v_o) begin
                    if (exp_q.size() > 0) exp_req = 1;
                    else exp_done = 1;
                end
            end
            prev_v   = req_v_o;
            prev_rdy = req_ready_and_i;
            prev_a   = req_addr_o;
            prev_d   = req_data_o;
        end
    end

    function automatic void push_model(input logic [NC-1:0] m,
                                       input logic [33:0] npc,
                                       input logic [1:0] im,
                                       input logic [1:0] dm);
        logic [33:0] cb;
        for (int c = 0; c < NC; c++) begin
            if (m[c]) begin
                cb = BASE + 34'(c) * 34'h100_0000;
                exp_q.push_back('{a: cb,           d: 64'd1});
                exp_q.push_back('{a: cb + 34'h010, d: 64'(im)});
                exp_q.push_back('{a: cb + 34'h018, d: 64'(dm)});
                exp_q.push_back('{a: cb + 34'h020, d: 64'(npc)});
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (m[c]) exp_q.push_back('{a: BASE + 34'(c) * 34'h100_0000,
                                        d: 64'd0});
        end
    endfunction

    task automatic run_seq(input logic [NC-1:0] m, input logic [33:0] npc,
                           input logic [1:0] im, input logic [1:0] dm,
                           input bit exp_err, input int drop,
                           input int bp, input bit stray);
        int          n;
        logic [63:0] r;
        push_model(m, npc, im, dm);
        acc_count     = 0;
        stall_cnt     = 0;
        drop_idx      = drop;
        bp_hold       = bp;
        core_mask_i   = m;
        npc_i         = npc;
        icache_mode_i = im;
        dcache_mode_i = dm;
        start_i       = 1'b1;
        if (stray) begin
            slave_en = 1'b0;
            resp_v_i = 1'b1;
        end
        @(posedge clk);
        #2;
        start_i = 1'b0;
        if (stray) begin
            resp_v_i = 1'b0;
            slave_en = 1'b1;
        end
        r = {$urandom, $urandom};
        core_mask_i   = r[NC-1:0];
        npc_i         = r[45:12];
        icache_mode_i = r[63:62];
        dcache_mode_i = r[61:60];
        @(negedge clk);
        check("start_err", error_o, 64'(stray));
        if (m == 0) begin
            check("empty_done", done_o, 1);
            check("empty_req", req_v_o, 0);
        end else begin
            check("start_req", req_v_o, 1);
            check("start_busy", busy_o, 1);
        end
        n = 0;
        while (!done_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("seq_done", done_o, 1);
        check("seq_err", error_o, 64'(exp_err));
        if (drop >= 0) begin
            check("tmo_cycles", 64'(cyc - acc_cyc), TMO + 1);
            check("tmo_writes", 64'(acc_count), 64'(drop + 1));
            exp_q.delete();
        end else begin
            check("writes", 64'(acc_count), 64'(5 * $countones(m)));
            check("left", 64'(exp_q.size()), 0);
        end
        if (bp > 0) check("stall", 64'(stall_cnt), 64'(bp));
        drop_idx = -1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [63:0] r;
        int          n;
        repeat (3) @(posedge clk);
        #2;
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_req_v", req_v_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", error_o, 0);
        check("rst_addr", req_addr_o, 0);
        @(posedge clk);
        #2;

        force_ready = 1'b1;
        lat_max     = 0;
        run_seq(4'b0011, 34'h0_8000_0000, 2'd1, 2'd1, 0, -1, 0, 0);
        run_seq(4'b0010, 34'h0_8000_0000, 2'd1, 2'd1, 0, -1, 0, 0);
        run_seq(4'b0000, 34'h0_1234_0000, 2'd2, 2'd3, 0, -1, 0, 0);
        run_seq(4'b0100, 34'h3_0000_0004, 2'd2, 2'd3, 0, -1, 7, 0);

        force_ready = 1'b0;
        lat_max     = 2;
        run_seq(4'b0011, 34'h0_8000_0000, 2'd3, 2'd0, 1, 2, 0, 0);
        run_seq(4'b1000, 34'h1_0000_0000, 2'd0, 2'd2, 0, -1, 0, 0);
        run_seq(4'b0101, 34'h0_0000_1000, 2'd1, 2'd2, 1, -1, 0, 1);

        for (int k = 0; k < 12; k++) begin
            r           = {$urandom, $urandom};
            force_ready = r[0];
            lat_max     = int'(r[2:1]);
            run_seq(r[7:4], r[63:30], r[9:8], r[11:10], 0, -1, 0, 0);
        end

        force_ready = 1'b0;
        lat_max     = 3;
        push_model(4'b1111, 34'h0_0000_4000, 2'd1, 2'd1);
        acc_count     = 0;
        core_mask_i   = 4'b1111;
        npc_i         = 34'h0_0000_4000;
        icache_mode_i = 2'd1;
        dcache_mode_i = 2'd1;
        start_i       = 1'b1;
        @(posedge clk);
        #2;
        start_i = 1'b0;
        n = 0;
        while (!(acc_count >= 2 && busy_o && !req_v_o) && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reached_wait", 64'(busy_o && !req_v_o), 1);
        slave_en        = 1'b0;
        resp_v_i        = 1'b0;
        req_ready_and_i = 1'b0;
        reset_i         = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_v", req_v_o, 0);
        check("mid_rst_addr", req_addr_o, 0);
        check("mid_rst_data", req_data_o, 0);
        check("mid_rst_yumi", resp_yumi_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_err", error_o, 0);
        @(posedge clk);
        #2;
        resp_v_i = 1'b1;
        @(negedge clk);
        check("stray_yumi", resp_yumi_o, 1);
        @(posedge clk);
        #2;
        resp_v_i = 1'b0;
        @(negedge clk);
        check("stray_err", error_o, 1);
        check("stray_busy", busy_o, 0);
        check("stray_done", done_o, 0);
        check("stray_v", req_v_o, 0);
        @(posedge clk);
        #2;
        slave_en = 1'b1;
        run_seq(4'b1001, 34'h2_0000_0010, 2'd3, 2'd1, 0, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_zynq_cfg_sequencer.md
Name: bp_zynq_cfg_sequencer

Overview:
- Parametrised multicore successor to the fixed per-build core configuration.
- Runtime sequencer that programs every enabled BlackParrot core's cfg bus through a BedRock-style write request/response channel, then releases all cores from freeze.
- Sits between the Zynq PS-facing control registers and the host/cfg network; replaces host software poking each core's cfg registers one by one.

Parameters:
- num_core_p, 2, number of cores to sequence (1..16).
- paddr_width_p, 34, request address width.
- data_width_p, 64, request data width.
- cfg_base_p, 34'h0020_0000, cfg address of core 0.
- core_stride_lg_p, 24, log2 address stride between consecutive cores' cfg spaces.
- timeout_p, 1024, max cycles to wait for a write response.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  begin sequence; sampled only in IDLE or DONE
- core_mask_i  in  num_core_p  cores to program; bit n = core n
- npc_i  in  paddr_width_p  boot PC written to every enabled core
- icache_mode_i  in  2  icache mode value
- dcache_mode_i  in  2  dcache mode value
- req_v_o  out  1  write request valid
- req_ready_and_i  in  1  request accepted when high with req_v_o
- req_addr_o  out  paddr_width_p  write address
- req_data_o  out  data_width_p  write data, zero-extended
- resp_v_i  in  1  write response valid
- resp_yumi_o  out  1  response consumed
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence finished; level
- error_o  out  1  sticky: timeout or unexpected response

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset: all outputs 0, FSM in IDLE, counters 0, error_o 0. A mid-sequence reset abandons the sequence without issuing further requests.
- Register offsets, added to cfg_base_p + (core << core_stride_lg_p):
  - freeze 0x000
  - icache_mode 0x010
  - dcache_mode 0x018
  - npc 0x020
- Phase A, for each enabled core in ascending index: write freeze=1, then icache_mode, then dcache_mode, then npc.
- Phase B, for each enabled core in ascending index: write freeze=0. No core is unfrozen until every core has been configured.
- Disabled cores are skipped with no bubble cycles. The next enabled index comes from a priority search over the latched mask.
- start_i latches core_mask_i, npc_i and both mode inputs. Later input changes have no effect until the next start.
- FSM states:
  - IDLE: start_i=1 goes to SEND, or to DONE if the mask is 0; clears error_o.
  - SEND: req_v_o=1 with stable addr/data until req_ready_and_i=1, then go to WAIT and clear the timeout counter.
  - WAIT: resp_yumi_o=resp_v_i. On response, advance the write pointer; go to SEND if writes remain, otherwise DONE.
    - Each WAIT cycle without a response increments the timeout counter.
    - When the counter reaches timeout_p: set error_o and go to DONE, aborting the remaining writes.
  - DONE: done_o=1. start_i=1 restarts exactly as from IDLE, including clearing error_o.
- Handshake rules:
  - At most one write outstanding.
  - req_v_o never depends combinationally on req_ready_and_i.
  - req_v_o is not withdrawn once raised until accepted.
- busy_o=1 in SEND and WAIT.
- Timing:
  - start_i at cycle t gives req_v_o at t+1.
  - A response at cycle r gives the next req_v_o at r+1.
  - A mask-0 start gives done_o at t+1.
- Unexpected response (resp_v_i outside WAIT): resp_yumi_o=1 to drain it, error_o set, FSM state unchanged.
- Simultaneous start_i with a response arriving in DONE: the response is unexpected (error_o set); the restart still proceeds, and the error set wins over the start clear.
- Total writes = 5 × popcount(mask).
- Data width rules: npc is zero-extended to data_width_p; mode values are zero-extended.

Test Plan:
- Basic sequence:
  - Stimulus: num_core_p=2, mask=2'b11, npc=0x8000_0000, icache=1, dcache=1; ready and response 1 cycle after each request.
  - Required: 10 writes in this order:
    - 0x200000=1, 0x200010=1, 0x200018=1, 0x200020=0x80000000
    - 0x1200000=1, then core 1's three configuration writes
    - 0x200000=0, 0x1200000=0
  - Then done_o=1 and error_o=0.
- Sparse mask:
  - Stimulus: mask=2'b10.
  - Required: 5 writes, all to core 1 addresses (0x1200000 upward); no core-0 address appears.
- Empty mask:
  - Stimulus: mask=0.
  - Required: done_o=1 one cycle after start; req_v_o never asserted.
- Backpressure:
  - Stimulus: req_ready_and_i held low for 7 cycles.
  - Required: req_addr_o and req_data_o stable throughout; exactly one acceptance.
- Timeout:
  - Stimulus: timeout_p=16; no response to the 3rd write.
  - Required: error_o=1 and done_o=1 after 16 WAIT cycles; no 4th request issued.
  - Follow-up: a restart clears error_o.
- Reset mid-operation:
  - Stimulus: reset_i in WAIT, then a stray resp_v_i after reset.
  - Required: all outputs 0 after reset; the stray response is drained with error_o=1.
